// File: rtl/instruction_decoder.sv
// instruction_decoder
// Takes the instruction word shifted in over SPI from the Raspberry Pi and turns
// each completed frame into one command for the accelerator core.
//
// The chip-select (cs1, active low) is synchronised into the clk domain. A frame
// is armed on its falling edge and completes on the following rising edge. The
// word is then snapshotted, the opcode is checked, and the command is offered
// on a valid/ready handshake.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   RPi_inst[N-1:0]        shifted word, stable while cs1 is high
//   cs1                    SPI chip-select, active low, asynchronous to clk
//   cmd_valid / cmd_ready  command handshake
//   cmd_op/addr/a/b        decoded fields, held stable while cmd_valid=1
//   err_count              saturating count of rejected frames
//   ovf_count              saturating count of frames dropped during ISSUE
//   ovf_flag               sticky overrun indicator
//   clear_stats            synchronous clear of err_count, ovf_count and ovf_flag
//
// Optional build macro INST_CHECKSUM_EN: when defined, RPi_inst[7:0] must equal
// the XOR of all other bytes of the word. A frame that fails this check is
// rejected before its opcode is looked at.
module instruction_decoder #(
    parameter int N      = 80,
    parameter int OP_W   = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      RPi_inst,
    input  logic              cs1,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [OP_W-1:0]   cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_a,
    output logic [DATA_W-1:0] cmd_b,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              ovf_flag,
    input  logic              clear_stats
);

    localparam logic [OP_W-1:0]  OP_WRITE    = OP_W'(8'h01);
    localparam logic [OP_W-1:0]  OP_READ     = OP_W'(8'h02);
    localparam logic [OP_W-1:0]  OP_EXEC     = OP_W'(8'h03);
    localparam logic [OP_W-1:0]  OP_NOP_SYNC = OP_W'(8'h04);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DECODE  = 3'd3,
        ISSUE   = 3'd4
    } state_t;

    state_t              state_r, state_next_s, ret_state_s;
    logic                cs_meta_r, cs_sync_r, cs_dly_r;
    logic                fall_s, rise_s;
    logic                op_known_s, op_nop_s, ck_bad_s, frame_bad_s;
    logic                cmd_valid_r, valid_next_s;
    logic [OP_W-1:0]     cmd_op_r;
    logic [ADDR_W-1:0]   cmd_addr_r;
    logic [DATA_W-1:0]   cmd_a_r, cmd_b_r;
    logic [CNT_W-1:0]    err_count_r, err_next_s;
    logic [CNT_W-1:0]    ovf_count_r, ovf_next_s;
    logic                ovf_flag_r, flag_next_s;

`ifdef INST_CHECKSUM_EN
    // XOR of every byte of the word except the lowest one, which carries the checksum.
    function automatic logic [7:0] byte_xor(input logic [N-1:0] word);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 1; i < N / 8; i++) begin
            acc = acc ^ word[i*8 +: 8];
        end
        return acc;
    endfunction
`endif

    assign fall_s = cs_dly_r & ~cs_sync_r;
    assign rise_s = cs_sync_r & ~cs_dly_r;

    // Two-flop synchroniser on cs1 plus a delay stage for edge detection; idles deasserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta_r <= 1'b1;
            cs_sync_r <= 1'b1;
            cs_dly_r  <= 1'b1;
        end else begin
            cs_meta_r <= cs1;
            cs_sync_r <= cs_meta_r;
            cs_dly_r  <= cs_sync_r;
        end
    end

    // Opcode and optional checksum validation of the captured word.
    always_comb begin
        op_known_s = (cmd_op_r == OP_WRITE) || (cmd_op_r == OP_READ) || (cmd_op_r == OP_EXEC);
        op_nop_s   = (cmd_op_r == OP_NOP_SYNC);
`ifdef INST_CHECKSUM_EN
        ck_bad_s   = (byte_xor({cmd_op_r, cmd_addr_r, cmd_a_r, cmd_b_r}) != cmd_b_r[7:0]);
`else
        ck_bad_s   = 1'b0;
`endif
        frame_bad_s = ck_bad_s | ~(op_known_s | op_nop_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state. When a frame finishes while cs1 is already low again, the
    // new frame's fall has been seen, so return to ARMED instead of IDLE.
    always_comb begin
        ret_state_s  = cs_sync_r ? IDLE : ARMED;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_next_s = ARMED;
                else        state_next_s = IDLE;
            end
            ARMED: begin
                if (rise_s) state_next_s = CAPTURE;
                else        state_next_s = ARMED;
            end
            CAPTURE: state_next_s = DECODE;
            DECODE: begin
                if (frame_bad_s || op_nop_s) state_next_s = ret_state_s;
                else                         state_next_s = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) state_next_s = ret_state_s;
                else           state_next_s = ISSUE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered handshake and statistics outputs.
    always_comb begin
        valid_next_s = cmd_valid_r;
        err_next_s   = err_count_r;
        ovf_next_s   = ovf_count_r;
        flag_next_s  = ovf_flag_r;
        if ((state_r == DECODE) && (state_next_s == ISSUE)) begin
            valid_next_s = 1'b1;
        end else if ((state_r == ISSUE) && cmd_ready) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = cmd_valid_r;
        end
        // clear_stats wins over an increment in the same cycle.
        if (clear_stats) begin
            err_next_s  = {CNT_W{1'b0}};
            ovf_next_s  = {CNT_W{1'b0}};
            flag_next_s = 1'b0;
        end else begin
            if ((state_r == DECODE) && frame_bad_s && (err_count_r != CNT_MAX)) begin
                err_next_s = err_count_r + CNT_W'(1'b1);
            end else begin
                err_next_s = err_count_r;
            end
            // A frame completing while a command is outstanding is dropped.
            if ((state_r == ISSUE) && rise_s) begin
                flag_next_s = 1'b1;
                if (ovf_count_r != CNT_MAX) ovf_next_s = ovf_count_r + CNT_W'(1'b1);
                else                        ovf_next_s = ovf_count_r;
            end else begin
                flag_next_s = ovf_flag_r;
                ovf_next_s  = ovf_count_r;
            end
        end
    end

    // Output registers for handshake and statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_r <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
            ovf_count_r <= {CNT_W{1'b0}};
            ovf_flag_r  <= 1'b0;
        end else begin
            cmd_valid_r <= valid_next_s;
            err_count_r <= err_next_s;
            ovf_count_r <= ovf_next_s;
            ovf_flag_r  <= flag_next_s;
        end
    end

    // Field snapshot; loaded only in CAPTURE, so fields never move while cmd_valid=1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_op_r   <= {OP_W{1'b0}};
            cmd_addr_r <= {ADDR_W{1'b0}};
            cmd_a_r    <= {DATA_W{1'b0}};
            cmd_b_r    <= {DATA_W{1'b0}};
        end else if (state_r == CAPTURE) begin
            cmd_op_r   <= RPi_inst[N-1 -: OP_W];
            cmd_addr_r <= RPi_inst[N-OP_W-1 -: ADDR_W];
            cmd_a_r    <= RPi_inst[N-OP_W-ADDR_W-1 -: DATA_W];
            cmd_b_r    <= RPi_inst[DATA_W-1:0];
        end else begin
            cmd_op_r   <= cmd_op_r;
            cmd_addr_r <= cmd_addr_r;
            cmd_a_r    <= cmd_a_r;
            cmd_b_r    <= cmd_b_r;
        end
    end

    assign cmd_valid = cmd_valid_r;
    assign cmd_op    = cmd_op_r;
    assign cmd_addr  = cmd_addr_r;
    assign cmd_a     = cmd_a_r;
    assign cmd_b     = cmd_b_r;
    assign err_count = err_count_r;
    assign ovf_count = ovf_count_r;
    assign ovf_flag  = ovf_flag_r;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: a scoreboard of expected
// commands is filled as frames are sent and drained as the DUT offers them.
module tb_instruction_decoder;

    localparam int N = 80;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  RPi_inst;
    logic          cs1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_op;
    logic [7:0]    cmd_addr;
    logic [31:0]   cmd_a;
    logic [31:0]   cmd_b;
    logic [7:0]    err_count;
    logic [7:0]    ovf_count;
    logic          ovf_flag;
    logic          clear_stats;

    int            checks_total  = 0;
    int            checks_passed = 0;
    logic [N-1:0]  exp_q[$];
    int            exp_err = 0;
    logic [N-1:0]  mon_w;

    always #5 clk = ~clk;

    instruction_decoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .RPi_inst    (RPi_inst),
        .cs1         (cs1),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .err_count   (err_count),
        .ovf_count   (ovf_count),
        .ovf_flag    (ovf_flag),
        .clear_stats (clear_stats)
    );

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ck_byte(input logic [N-1:0] w);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 1; i < N / 8; i++) acc = acc ^ w[i*8 +: 8];
        return acc;
    endfunction

    // Make a word legal for the current build (fills the checksum byte when enabled).
    function automatic logic [N-1:0] seal(input logic [N-1:0] w);
`ifdef INST_CHECKSUM_EN
        return {w[N-1:8], ck_byte(w)};
`else
        return w;
`endif
    endfunction

    function automatic bit ck_ok(input logic [N-1:0] w);
`ifdef INST_CHECKSUM_EN
        return (ck_byte(w) == w[7:0]);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit is_good(input logic [N-1:0] w);
        logic [7:0] op;
        op = w[N-1 -: 8];
        return ck_ok(w) && (op == 8'h01 || op == 8'h02 || op == 8'h03);
    endfunction

    function automatic bit is_err(input logic [N-1:0] w);
        logic [7:0] op;
        op = w[N-1 -: 8];
        return !ck_ok(w) || !(op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h04);
    endfunction

    // One SPI frame: cs1 low for three cycles, then high; returns just after
    // cs1 rises so the next posedge is the first one to sample it high.
    task automatic send_frame(input logic [N-1:0] w, input bit drop);
        @(posedge clk); #1;
        RPi_inst = w;
        cs1      = 1'b0;
        if (!drop && is_good(w)) exp_q.push_back(w);
        if (!drop && is_err(w) && exp_err < 255) exp_err++;
        repeat (3) @(posedge clk);
        #1 cs1 = 1'b1;
    endtask

    // Scoreboard monitor: any offered command must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && cmd_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_cmd", N'(cmd_valid), N'(1'b0));
            end else begin
                mon_w = exp_q[0];
                check_val("cmd_fields", {cmd_op, cmd_addr, cmd_a, cmd_b}, mon_w);
                if (cmd_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] w;
        logic [N-1:0] flip;
        logic [7:0]   ops [8];
        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'hFF, 8'h7F, 8'h02};

        reset_n     = 1'b1;
        cs1         = 1'b0;
        cmd_ready   = 1'b1;
        clear_stats = 1'b0;
        RPi_inst    = seal(80'h01_05_DEADBEEF_00000010);
        #1 reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", N'(cmd_valid), N'(1'b0));
        check_val("rst_fields", {cmd_op, cmd_addr, cmd_a, cmd_b}, N'(1'b0));
        check_val("rst_err", N'(err_count), N'(8'd0));
        check_val("rst_ovf", N'(ovf_count), N'(8'd0));
        check_val("rst_flag", N'(ovf_flag), N'(1'b0));

        // cs1 rises while reset is held: no fall is ever seen, so nothing happens.
        cs1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_val("nofall_valid", N'(cmd_valid), N'(1'b0));
        check_val("nofall_err", N'(err_count), N'(8'd0));
        check_val("nofall_ovf", N'(ovf_count), N'(8'd0));

        // Latency and single-cycle handshake with cmd_ready high.
        w = seal(80'h01_05_DEADBEEF_00000010);
        send_frame(w, 1'b0);
        repeat (4) @(posedge clk);
        #1 check_val("lat_e4_low", N'(cmd_valid), N'(1'b0));
        @(posedge clk);
        #1 check_val("lat_e5_high", N'(cmd_valid), N'(1'b1));
        check_val("lat_op", N'(cmd_op), N'(8'h01));
        check_val("lat_addr", N'(cmd_addr), N'(8'h05));
        check_val("lat_a", N'(cmd_a), N'(32'hDEADBEEF));
        check_val("lat_b", N'(cmd_b), N'(w[31:0]));
        @(posedge clk);
        #1 check_val("single_cycle", N'(cmd_valid), N'(1'b0));

        // Mixed opcodes with random payloads.
        for (int i = 0; i < 8; i++) begin
            w = seal({ops[i], 8'($urandom), 32'($urandom), 32'($urandom)});
            send_frame(w, 1'b0);
            repeat (8) @(posedge clk);
            #1 check_val("mix_err", N'(err_count), N'(exp_err));
        end

        // Invalid opcode: counts, then saturates, then clears.
        exp_err = 0;
        clear_stats = 1'b1;
        @(posedge clk);
        #1 clear_stats = 1'b0;
        w = seal({8'h7F, 8'h11, 32'h12345678, 32'h9ABCDEF0});
        send_frame(w, 1'b0);
        repeat (8) @(posedge clk);
        #1 check_val("bad_op_err1", N'(err_count), N'(8'd1));
        check_val("bad_op_novalid", N'(cmd_valid), N'(1'b0));
        for (int i = 0; i < 300; i++) begin
            send_frame(w, 1'b0);
            repeat (6) @(posedge clk);
        end
        #1 check_val("err_sat", N'(err_count), N'(8'd255));
        check_val("err_model", N'(err_count), N'(exp_err));
        @(posedge clk);
        #1 clear_stats = 1'b1;
        @(posedge clk);
        #1 clear_stats = 1'b0;
        exp_err = 0;
        check_val("err_cleared", N'(err_count), N'(8'd0));

        // Overrun: second frame completes while the first is still offered.
        cmd_ready = 1'b0;
        w = seal({8'h02, 8'hA5, 32'h0BADF00D, 32'hCAFE0001});
        send_frame(w, 1'b0);
        repeat (8) @(posedge clk);
        #1 check_val("ovf_first_valid", N'(cmd_valid), N'(1'b1));
        w = seal({8'h01, 8'h3C, 32'h11112222, 32'h33334444});
        send_frame(w, 1'b1);
        repeat (8) @(posedge clk);
        #1 check_val("ovf_count", N'(ovf_count), N'(8'd1));
        check_val("ovf_flag", N'(ovf_flag), N'(1'b1));
        check_val("ovf_err_same", N'(err_count), N'(8'd0));
        check_val("ovf_still_valid", N'(cmd_valid), N'(1'b1));
        cmd_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_val("ovf_no_second", N'(cmd_valid), N'(1'b0));
        check_val("ovf_sb_empty", N'(exp_q.size()), N'(1'b0));
        check_val("ovf_flag_sticky", N'(ovf_flag), N'(1'b1));
        clear_stats = 1'b1;
        @(posedge clk);
        #1 clear_stats = 1'b0;
        check_val("ovf_cleared", N'(ovf_count), N'(8'd0));
        check_val("flag_cleared", N'(ovf_flag), N'(1'b0));

        // Reset while a command is outstanding.
        cmd_ready = 1'b0;
        w = seal({8'h03, 8'h77, 32'hFEEDFACE, 32'h00C0FFEE});
        send_frame(w, 1'b0);
        repeat (8) @(posedge clk);
        #1 check_val("pre_rst_valid", N'(cmd_valid), N'(1'b1));
        reset_n = 1'b0;
        #1 check_val("async_rst_valid", N'(cmd_valid), N'(1'b0));
        exp_q.delete();
        exp_err = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        w = seal({8'h01, 8'h42, 32'hA5A5A5A5, 32'h5A5A5A5A});
        send_frame(w, 1'b0);
        repeat (4) @(posedge clk);
        #1 check_val("post_rst_e4", N'(cmd_valid), N'(1'b0));
        @(posedge clk);
        #1 check_val("post_rst_e5", N'(cmd_valid), N'(1'b1));
        repeat (4) @(posedge clk);
        #1 check_val("post_rst_sb", N'(exp_q.size()), N'(1'b0));

`ifdef INST_CHECKSUM_EN
        // One flipped bit breaks the checksum: rejected and counted.
        flip = 80'h1;
        flip = flip << 40;
        w = seal({8'h02, 8'h09, 32'h01020304, 32'h05060708}) ^ flip;
        send_frame(w, 1'b0);
        repeat (8) @(posedge clk);
        #1 check_val("ck_bad_err", N'(err_count), N'(8'd1));
        check_val("ck_bad_model", N'(err_count), N'(exp_err));
`else
        flip = '0;
`endif
        repeat (4) @(posedge clk);
        #1 check_val("final_sb_empty", N'(exp_q.size()), N'(1'b0));
        check_val("final_valid", N'(cmd_valid), N'(1'b0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
